// File: rtl/result_wb_arbiter.sv
// Result writeback arbiter: per-producer FIFOs feeding NUM_WB registered writeback
// ports through a round-robin scheduler, with sqN-based mispredict flush.
package result_wb_pkg;
  typedef struct packed {
    logic [31:0] result;
    logic [6:0]  tagDst;
    logic [6:0]  sqN;
    logic [3:0]  flags;
    logic        doNotCommit;
    logic        valid;
  } RES_UOp;
endpackage

module result_wb_arbiter
  import result_wb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int NUM_WB = 2,
  parameter int DEPTH  = 2,
  parameter int SQN_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  RES_UOp            IN_uop [NUM_IN],
  output logic [NUM_IN-1:0] OUT_stall,
  input  logic              IN_flushValid,
  input  logic [SQN_W-1:0]  IN_flushSqN,
  output RES_UOp            OUT_uop [NUM_WB]
);

  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  // Handshake: a producer may present .valid only while its OUT_stall bit is low;
  // a presented uop is accepted at the rising edge unless a flush kills it.

  // Each FIFO is kept compacted: live entries occupy slots 0..count-1, head in slot 0.
  RES_UOp            r_q   [NUM_IN][DEPTH];
  logic [DEPTH-1:0]  r_vld [NUM_IN];
  logic [IW-1:0]     r_rr;
  RES_UOp            r_out [NUM_WB];

  logic [DEPTH-1:0]  w_kill  [NUM_IN];
  logic [NUM_IN-1:0] w_elig;
  logic [NUM_IN-1:0] w_enq;
  logic [NUM_IN-1:0] w_grant;
  logic [IW-1:0]     w_port  [NUM_WB];
  logic [NUM_WB-1:0] w_port_vld;
  logic [IW-1:0]     w_rr_nxt;
  RES_UOp            w_q_nxt   [NUM_IN][DEPTH];
  logic [DEPTH-1:0]  w_vld_nxt [NUM_IN];
  RES_UOp            w_out_nxt [NUM_WB];

  // Wrap-safe "strictly younger": signed difference is positive.
  function automatic logic is_younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] f);
    logic [SQN_W-1:0] d;
    d = a - f;
    return (d != '0) && !d[SQN_W-1];
  endfunction

  always_comb begin : kill_logic
    for (int i = 0; i < NUM_IN; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        w_kill[i][j] = IN_flushValid && is_younger(r_q[i][j].sqN, IN_flushSqN);
      end
      w_elig[i] = r_vld[i][0] && !w_kill[i][0];
      w_enq[i]  = IN_uop[i].valid && !OUT_stall[i] &&
                  !(IN_flushValid && is_younger(IN_uop[i].sqN, IN_flushSqN));
    end
  end

  always_comb begin : arbitrate
    int n;
    int idx;
    w_grant    = '0;
    w_port_vld = '0;
    w_rr_nxt   = r_rr;
    for (int p = 0; p < NUM_WB; p++) w_port[p] = '0;
    n = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (int'(r_rr) + k) % NUM_IN;
      if (w_elig[idx] && (n < NUM_WB)) begin
        w_grant[idx]  = 1'b1;
        w_port[n]     = IW'(idx);
        w_port_vld[n] = 1'b1;
        w_rr_nxt      = IW'((idx + 1) % NUM_IN);
        n++;
      end
    end
  end

  // Drop the popped head and flushed entries, repack, then append the new uop.
  always_comb begin : fifo_next
    int c;
    for (int i = 0; i < NUM_IN; i++) begin
      w_vld_nxt[i] = '0;
      for (int j = 0; j < DEPTH; j++) w_q_nxt[i][j] = '0;
      c = 0;
      for (int j = 0; j < DEPTH; j++) begin
        if (r_vld[i][j] && !((j == 0) && w_grant[i]) && !w_kill[i][j]) begin
          w_q_nxt[i][c]   = r_q[i][j];
          w_vld_nxt[i][c] = 1'b1;
          c++;
        end
      end
      if (w_enq[i] && (c < DEPTH)) begin
        w_q_nxt[i][c]   = IN_uop[i];
        w_vld_nxt[i][c] = 1'b1;
      end
    end
  end

  always_comb begin : out_next
    for (int p = 0; p < NUM_WB; p++) begin
      w_out_nxt[p] = '0;
      if (w_port_vld[p]) begin
        w_out_nxt[p]       = r_q[w_port[p]][0];
        w_out_nxt[p].valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        r_vld[i] <= '0;
        for (int j = 0; j < DEPTH; j++) r_q[i][j] <= '0;
      end
      for (int p = 0; p < NUM_WB; p++) r_out[p] <= '0;
    end else begin
      r_rr <= w_rr_nxt;
      for (int i = 0; i < NUM_IN; i++) begin
        r_vld[i] <= w_vld_nxt[i];
        for (int j = 0; j < DEPTH; j++) r_q[i][j] <= w_q_nxt[i][j];
      end
      for (int p = 0; p < NUM_WB; p++) r_out[p] <= w_out_nxt[p];
    end
  end

  // Full means the last slot is live; depends only on registered state.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) OUT_stall[i] = r_vld[i][DEPTH-1];
  end

  assign OUT_uop = r_out;

  always_ff @(posedge clk) begin : protocol_check
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        assert (!(IN_uop[i].valid && OUT_stall[i]))
          else $error("result_wb_arbiter: producer %0d pushed while stalled", i);
      end
    end
  end

endmodule

// File: tb/tb_result_wb_arbiter.sv
// Self-checking bench for result_wb_arbiter: directed steps plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_result_wb_arbiter;
  import result_wb_pkg::*;

  localparam int NUM_IN = 4;
  localparam int NUM_WB = 2;
  localparam int DEPTH  = 2;
  localparam int SQN_W  = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  RES_UOp            in_uop [NUM_IN];
  logic [NUM_IN-1:0] out_stall;
  logic              flush_v;
  logic [SQN_W-1:0]  flush_sqn;
  RES_UOp            out_uop [NUM_WB];

  result_wb_arbiter #(.NUM_IN(NUM_IN), .NUM_WB(NUM_WB), .DEPTH(DEPTH), .SQN_W(SQN_W)) dut (
    .clk(clk), .rst(rst_n), .IN_uop(in_uop), .OUT_stall(out_stall),
    .IN_flushValid(flush_v), .IN_flushSqN(flush_sqn), .OUT_uop(out_uop)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: one queue per producer plus a round-robin start index
  RES_UOp            mq [NUM_IN][$];
  int                m_rr;
  RES_UOp            exp_out [NUM_WB];
  logic [NUM_IN-1:0] exp_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_young(input logic [6:0] a);
    int d;
    d = (int'(a) - int'(flush_sqn) + 128) % 128;
    return flush_v && (d > 0) && (d < 64);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_IN; i++) mq[i].delete();
    m_rr = 0;
    for (int p = 0; p < NUM_WB; p++) exp_out[p] = '0;
    exp_stall = '0;
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic [NUM_IN-1:0] pre_full;
    int n, idx, last;
    RES_UOp t[$];
    for (int i = 0; i < NUM_IN; i++) pre_full[i] = (mq[i].size() == DEPTH);
    for (int p = 0; p < NUM_WB; p++) exp_out[p] = '0;
    n = 0;
    last = -1;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (m_rr + k) % NUM_IN;
      if (n < NUM_WB && mq[idx].size() > 0 && !m_young(mq[idx][0].sqN)) begin
        exp_out[n] = mq[idx].pop_front();
        exp_out[n].valid = 1'b1;
        n++;
        last = idx;
      end
    end
    if (last >= 0) m_rr = (last + 1) % NUM_IN;
    for (int i = 0; i < NUM_IN; i++) begin
      t = {};
      for (int j = 0; j < mq[i].size(); j++)
        if (!m_young(mq[i][j].sqN)) t.push_back(mq[i][j]);
      mq[i] = t;
      if (in_uop[i].valid && !pre_full[i] && !m_young(in_uop[i].sqN)) mq[i].push_back(in_uop[i]);
      exp_stall[i] = (mq[i].size() == DEPTH);
    end
  endtask

  task automatic compare_all();
    for (int p = 0; p < NUM_WB; p++) begin
      if (exp_out[p].valid) check($sformatf("out_uop%0d", p), 64'(out_uop[p]), 64'(exp_out[p]));
      else check($sformatf("out_valid%0d", p), 64'(out_uop[p].valid), 64'(0));
    end
    check("out_stall", 64'(out_stall), 64'(exp_stall));
  endtask

  // driver tasks
  task automatic clr_inputs();
    for (int i = 0; i < NUM_IN; i++) in_uop[i] = '0;
    flush_v = 1'b0;
    flush_sqn = '0;
  endtask

  task automatic drive(input int i, input logic [6:0] sqn, input logic [31:0] res);
    in_uop[i] = '0;
    in_uop[i].valid = 1'b1;
    in_uop[i].result = res;
    in_uop[i].tagDst = 7'(i);
    in_uop[i].sqN = sqn;
    in_uop[i].flags = 4'($urandom_range(0, 15));
    in_uop[i].doNotCommit = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_traffic(input int pct);
    for (int i = 0; i < NUM_IN; i++) begin
      in_uop[i] = '0;
      if (!exp_stall[i] && $urandom_range(0, 99) < pct)
        drive(i, 7'($urandom_range(0, 127)), $urandom);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  int gcnt [NUM_IN];
  int glast [NUM_IN];
  int gap_viol;
  int stall3_cycles;

  initial begin
    clr_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int p = 0; p < NUM_WB; p++) check("reset_out", 64'(out_uop[p]), 64'(0));
    check("reset_stall", 64'(out_stall), 64'(0));
    rst_n = 1'b1;
    tick();

    // single uop latency: enqueue edge, then grant edge
    drive(0, 7'd5, 32'hDEAD);
    tick();
    check("lat_early_valid", 64'(out_uop[0].valid), 64'(0));
    clr_inputs();
    tick();
    check("lat_valid", 64'(out_uop[0].valid), 64'(1));
    check("lat_result", 64'(out_uop[0].result), 64'(32'hDEAD));
    check("lat_sqn", 64'(out_uop[0].sqN), 64'(5));
    check("lat_port1", 64'(out_uop[1].valid), 64'(0));
    check("lat_stall", 64'(out_stall), 64'(0));

    // single uop on input 3 returns the pointer to 0
    drive(3, 7'd6, 32'h1234);
    tick();
    clr_inputs();
    tick();
    check("rr_wrap_tag", 64'(out_uop[0].tagDst), 64'(3));

    // all four inputs in one cycle
    for (int i = 0; i < NUM_IN; i++) drive(i, 7'(10 + i), 32'hA000 + 32'(i));
    tick();
    clr_inputs();
    tick();
    check("all4_p0", 64'(out_uop[0].tagDst), 64'(0));
    check("all4_p1", 64'(out_uop[1].tagDst), 64'(1));
    tick();
    check("all4_p2", 64'(out_uop[0].tagDst), 64'(2));
    check("all4_p3", 64'(out_uop[1].tagDst), 64'(3));
    tick();
    check("all4_drained", 64'({out_uop[1].valid, out_uop[0].valid}), 64'(0));

    // move the pointer to 2, then build FIFO0={3,8}, FIFO1={10}
    drive(0, 7'd20, 32'h20);
    drive(1, 7'd21, 32'h21);
    tick();
    clr_inputs();
    tick();
    drive(0, 7'd3, 32'h3);
    drive(1, 7'd10, 32'h10);
    drive(2, 7'd1, 32'h1);
    drive(3, 7'd2, 32'h2);
    tick();
    clr_inputs();
    drive(0, 7'd8, 32'h8);
    tick();
    clr_inputs();
    flush_v = 1'b1;
    flush_sqn = 7'd6;
    tick();
    check("flush_keep_valid", 64'(out_uop[0].valid), 64'(1));
    check("flush_keep_sqn", 64'(out_uop[0].sqN), 64'(3));
    check("flush_port1", 64'(out_uop[1].valid), 64'(0));
    clr_inputs();
    repeat (2) tick();
    check("flush_stall", 64'(out_stall), 64'(0));
    check("flush_no_leak", 64'({out_uop[1].valid, out_uop[0].valid}), 64'(0));

    // sqN wrap: flush at 126 kills sqN 1, keeps 125
    drive(0, 7'd1, 32'hB1);
    drive(1, 7'd125, 32'hB2);
    tick();
    clr_inputs();
    flush_v = 1'b1;
    flush_sqn = 7'd126;
    tick();
    check("wrap_keep_sqn", 64'(out_uop[0].sqN), 64'(125));
    check("wrap_port1", 64'(out_uop[1].valid), 64'(0));
    clr_inputs();
    tick();
    check("wrap_killed", 64'({out_uop[1].valid, out_uop[0].valid}), 64'(0));

    // saturation: fairness, bounded wait, stall while full
    for (int i = 0; i < NUM_IN; i++) begin
      gcnt[i] = 0;
      glast[i] = -1;
    end
    gap_viol = 0;
    stall3_cycles = 0;
    for (int c = 0; c < 100; c++) begin
      drive_traffic(100);
      tick();
      if (out_stall[3]) stall3_cycles++;
      for (int p = 0; p < NUM_WB; p++) begin
        if (out_uop[p].valid) begin
          int g;
          g = int'(out_uop[p].tagDst);
          gcnt[g]++;
          if (glast[g] >= 0 && (c - glast[g]) > 2) gap_viol++;
          glast[g] = c;
        end
      end
    end
    for (int i = 0; i < NUM_IN; i++)
      check($sformatf("fair_in%0d_ok", i), 64'(gcnt[i] >= 49 && gcnt[i] <= 51), 64'(1));
    check("max_wait", 64'(gap_viol), 64'(0));
    check("stall3_seen", 64'(stall3_cycles > 0), 64'(1));

    // asynchronous reset in the middle of a burst
    for (int c = 0; c < 3; c++) begin
      drive_traffic(100);
      tick();
    end
    rst_n = 1'b0;
    #1;
    for (int p = 0; p < NUM_WB; p++) check("midrst_valid", 64'(out_uop[p].valid), 64'(0));
    check("midrst_stall", 64'(out_stall), 64'(0));
    clr_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // randomized traffic with random flushes
    for (int c = 0; c < 400; c++) begin
      drive_traffic(60);
      flush_v = ($urandom_range(0, 9) == 0);
      flush_sqn = 7'($urandom_range(0, 127));
      tick();
    end
    clr_inputs();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
